// File: rtl/dmem_responder_if.sv
// Request/response bus between the miniRV CPU dmem port (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, byte-strobed store at accept, full-word load after LATENCY wait states.
// Optional range check via DMEM_RANGE_CHECK_EN; otherwise addresses alias modulo DEPTH_WORDS and rsp_err is 0.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            cap_we_q, cap_we_d;
    logic            cap_err_q, cap_err_d;
    logic [AW-1:0]   cap_idx_q, cap_idx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     off;
    logic [AW-1:0]   req_idx;
    logic            req_oor;
    logic            accept;
    logic            rd_we;
    logic            rd_err;
    logic [AW-1:0]   rd_idx;
    logic            load_rsp;
    logic            unused_bits;

    assign off     = bus.req_addr - BASE_ADDR;
    assign req_idx = off[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    assign req_oor     = ({1'b0, off} >= SPAN);
    assign bus.rsp_err = err_q;
`else
    assign req_oor     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign unused_bits = ^{off[1:0], off[31:AW+2], err_q};

    assign accept        = (state_q == IDLE) && bus.req_valid;
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;

    // With LATENCY=0 the response is loaded on the accept edge, so read from the live request.
    assign rd_we  = (state_q == IDLE) ? bus.req_we : cap_we_q;
    assign rd_err = (state_q == IDLE) ? req_oor    : cap_err_q;
    assign rd_idx = (state_q == IDLE) ? req_idx    : cap_idx_q;

    always_ff @(posedge clk) begin
        if (reset && accept && bus.req_we && !req_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wstrb[i]) begin
                    mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_we_d  = cap_we_q;
        cap_err_d = cap_err_q;
        cap_idx_d = cap_idx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        load_rsp  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cap_we_d  = bus.req_we;
                    cap_err_d = req_oor;
                    cap_idx_d = req_idx;
                    if (LAT != 4'd0) begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end else begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d  = RESP;
                    cnt_d    = 4'd0;
                    load_rsp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_rsp) begin
            rdata_d = (rd_we || rd_err) ? 32'h0 : mem[rd_idx];
            err_d   = rd_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cap_we_q  <= 1'b0;
            cap_err_q <= 1'b0;
            cap_idx_q <= '0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_we_q  <= cap_we_d;
            cap_err_q <= cap_err_d;
            cap_idx_q <= cap_idx_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: LATENCY=2 instance for functional scenarios, LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;
    localparam int LAT = 2;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder_if b0();
    dmem_responder_if b1();

    dmem_responder #(.LATENCY(LAT)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    dmem_responder #(.LATENCY(0))   dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int lat);
        lat = -1;
        @(negedge clk);
        b0.req_valid = 1'b1;
        b0.req_we    = we;
        b0.req_addr  = addr;
        b0.req_wdata = wdata;
        b0.req_wstrb = strb;
        for (int k = 0; k < 50 && !b0.req_ready; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        b0.req_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (b0.rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        rdata = b0.rsp_rdata;
        err   = b0.rsp_err;
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (b0.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", b0.req_ready); else passed++;
        checks++; if (b0.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", b0.rsp_valid); else passed++;
        checks++; if (b0.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", b0.rsp_rdata); else passed++;
        checks++; if (b0.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", b0.rsp_err); else passed++;
        checks++; if (b1.req_ready !== 1'b1) $display("FAIL reset_lat0_req_ready got %b want 1", b1.req_ready); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        req_t t[2];
        t[0] = '{1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        foreach (t[i]) begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            exp_t        e;
            e.rdata = t[i].exp_rdata; e.err = t[i].exp_err; e.acc = 0;
            sb.push_back(e);
            xact(t[i].we, t[i].addr, t[i].wdata, t[i].strb, rd, er, lat);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) $display("FAIL store_load[%0d] rdata got %h want %h", i, rd, e.rdata); else passed++;
            checks++; if (er !== e.err) $display("FAIL store_load[%0d] err got %b want %b", i, er, e.err); else passed++;
            checks++; if (lat != LAT) $display("FAIL store_load[%0d] latency got %0d want %0d", i, lat, LAT); else passed++;
        end
    endtask

    task automatic test_byte_lane();
        req_t t[4];
        t[0] = '{1'b1, 32'h1008, 32'h11223344, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b1, 32'h1008, 32'h0000AB00, 4'h2, 32'h0, 1'b0};
        t[2] = '{1'b0, 32'h100A, 32'h0, 4'h0, 32'h1122AB44, 1'b0};
        t[3] = '{1'b1, 32'h1008, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        foreach (t[i]) begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            exp_t        e;
            e.rdata = t[i].exp_rdata; e.err = t[i].exp_err; e.acc = 0;
            sb.push_back(e);
            xact(t[i].we, t[i].addr, t[i].wdata, t[i].strb, rd, er, lat);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) $display("FAIL byte_lane[%0d] rdata got %h want %h", i, rd, e.rdata); else passed++;
            checks++; if (er !== e.err) $display("FAIL byte_lane[%0d] err got %b want %b", i, er, e.err); else passed++;
            checks++; if (lat != LAT) $display("FAIL byte_lane[%0d] latency got %0d want %0d", i, lat, LAT); else passed++;
        end
        begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            xact(1'b0, 32'h1008, 32'h0, 4'h0, rd, er, lat);
            checks++; if (rd !== 32'h1122AB44) $display("FAIL byte_lane_zero_strb rdata got %h want 1122ab44", rd); else passed++;
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        int          lat;
        e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.acc = 0;
        sb.push_back(e);
        lat = -1;
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_addr = 32'h1004; b0.req_wstrb = 4'h0;
        for (int k = 0; k < 50 && !b0.req_ready; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        // Keep a conflicting store pending; it must never be accepted.
        b0.req_we = 1'b1; b0.req_wdata = 32'h0; b0.req_wstrb = 4'hF;
        for (int k = 0; k < 50; k++) begin
            if (b0.rsp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++; if (lat != LAT) $display("FAIL backpressure latency got %0d want %0d", lat, LAT); else passed++;
        for (int c = 0; c < 5; c++) begin
            checks++; if (b0.rsp_valid !== 1'b1) $display("FAIL bp_hold[%0d] rsp_valid got %b want 1", c, b0.rsp_valid); else passed++;
            checks++; if (b0.rsp_rdata !== e.rdata) $display("FAIL bp_hold[%0d] rdata got %h want %h", c, b0.rsp_rdata, e.rdata); else passed++;
            checks++; if (b0.req_ready !== 1'b0) $display("FAIL bp_hold[%0d] req_ready got %b want 0", c, b0.req_ready); else passed++;
            if (c < 4) @(negedge clk);
        end
        b0.req_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
        checks++; if (b0.rsp_valid !== 1'b0) $display("FAIL bp_release rsp_valid got %b want 0", b0.rsp_valid); else passed++;
        checks++; if (b0.req_ready !== 1'b1) $display("FAIL bp_release req_ready got %b want 1", b0.req_ready); else passed++;
        xact(1'b0, 32'h1004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL bp_no_second_accept rdata got %h want deadbeef", rd); else passed++;
    endtask

    task automatic test_range();
        req_t t[4];
        t[0] = '{1'b1, 32'h1000, 32'h01020304, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF, 32'h0, RC};
        t[2] = '{1'b0, 32'h2000, 32'h0, 4'h0, RC ? 32'h0 : 32'hFFFFFFFF, RC};
        t[3] = '{1'b0, 32'h1000, 32'h0, 4'h0, RC ? 32'h01020304 : 32'hFFFFFFFF, 1'b0};
        foreach (t[i]) begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            exp_t        e;
            e.rdata = t[i].exp_rdata; e.err = t[i].exp_err; e.acc = 0;
            sb.push_back(e);
            xact(t[i].we, t[i].addr, t[i].wdata, t[i].strb, rd, er, lat);
            e = sb.pop_front();
            checks++; if (rd !== e.rdata) $display("FAIL range[%0d] rdata got %h want %h", i, rd, e.rdata); else passed++;
            checks++; if (er !== e.err) $display("FAIL range[%0d] err got %b want %b", i, er, e.err); else passed++;
            checks++; if (lat != LAT) $display("FAIL range[%0d] latency got %0d want %0d", i, lat, LAT); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic        seen;
        logic [31:0] rd;
        logic        er;
        int          lat;
        seen = 1'b0;
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_addr = 32'h1004;
        for (int k = 0; k < 50 && !b0.req_ready; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        b0.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (b0.req_ready !== 1'b1) $display("FAIL reset_mid req_ready got %b want 1", b0.req_ready); else passed++;
        for (int k = 0; k < 10; k++) begin
            if (b0.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) $display("FAIL reset_mid rsp_valid_seen got %b want 0", seen); else passed++;
        xact(1'b0, 32'h1004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL reset_mid_preserved rdata got %h want deadbeef", rd); else passed++;
        checks++; if (er !== 1'b0) $display("FAIL reset_mid_preserved err got %b want 0", er); else passed++;
        checks++; if (lat != LAT) $display("FAIL reset_mid_preserved latency got %0d want %0d", lat, LAT); else passed++;
    endtask

    task automatic test_back_to_back();
        req_t t[5];
        int   i;
        int   last_acc;
        t[0] = '{1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b1, 32'h1004, 32'h12345678, 4'hF, 32'h0, 1'b0};
        t[2] = '{1'b0, 32'h1000, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
        t[3] = '{1'b0, 32'h1004, 32'h0, 4'h0, 32'h12345678, 1'b0};
        t[4] = '{1'b0, 32'h1000, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
        i = 0;
        last_acc = 0;
        b1.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (b1.rsp_valid) begin
                exp_t e;
                e = sb.pop_front();
                checks++; if (b1.rsp_rdata !== e.rdata) $display("FAIL b2b rdata got %h want %h", b1.rsp_rdata, e.rdata); else passed++;
                checks++; if (b1.rsp_err !== e.err) $display("FAIL b2b err got %b want %b", b1.rsp_err, e.err); else passed++;
                checks++; if (cyc - e.acc != 1) $display("FAIL b2b latency got %0d want 1", cyc - e.acc); else passed++;
            end
            if (b1.req_ready && i < 5) begin
                exp_t e;
                b1.req_valid = 1'b1; b1.req_we = t[i].we; b1.req_addr = t[i].addr;
                b1.req_wdata = t[i].wdata; b1.req_wstrb = t[i].strb;
                e.rdata = t[i].exp_rdata; e.err = t[i].exp_err; e.acc = cyc;
                sb.push_back(e);
                if (i > 0) begin
                    checks++; if (cyc - last_acc != 2) $display("FAIL b2b accept_spacing got %0d want 2", cyc - last_acc); else passed++;
                end
                last_acc = cyc;
                i++;
            end
            if (i == 5 && sb.size() == 0) break;
        end
        b1.req_valid = 1'b0;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        checks++; if (i != 5 || sb.size() != 0) $display("FAIL b2b completion issued %0d want 5 pending %0d want 0", i, sb.size()); else passed++;
        sb.delete();
    endtask

    initial begin
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'h0; b0.req_wdata = 32'h0;
        b0.req_wstrb = 4'h0; b0.rsp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        b1.req_wstrb = 4'h0; b1.rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_lane();
        test_backpressure();
        test_range();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the miniRV CPU load/store port.
- The CPU is the initiator. This block accepts one request at a time over a valid/ready handshake and applies byte-strobed writes.
- It returns full-word read data after a programmable number of wait states. The CPU does the byte select and zero-extend for lbu.
- It sits between the CPU dmem port and the on-chip data RAM, and can stand in for a slower external memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2).
- LATENCY, 2, wait-state cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_1000, byte address of word 0.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] are ignored for array indexing.
- req_wdata  in  32  store data, already lane-aligned by the CPU.
- req_wstrb  in  4  byte-lane write enables; bit i enables wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  CPU accepts the response.
- rsp_rdata  out  32  full word read; 0 for stores.
- rsp_err  out  1  address out of range (see Optional Feature).

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are NOT cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - Acceptance happens at a posedge with req_valid&&req_ready. The block captures we, addr and error flag.
  - Store: lanes with wstrb=1 are written at this same edge; other lanes are unchanged. wstrb=0 with we=1 writes nothing but still produces a response.
  - Next state is WAIT with counter=LATENCY if LATENCY>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle. When it reaches 1, the next state is RESP.
- Entering RESP:
  - Load: rsp_rdata = array[(addr-BASE_ADDR)>>2], sampled at the transition edge, so it reflects all earlier stores.
  - Store: rsp_rdata=0.
  - rsp_err is set from the captured flag.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err stay stable until the posedge with rsp_ready=1, then the block returns to IDLE and rsp_valid drops.
- Latency:
  - Acceptance at edge N gives rsp_valid high in the cycle after edge N+1+LATENCY-1, i.e. LATENCY+1 cycles after the accept cycle.
  - LATENCY=0 gives rsp_valid in the cycle immediately after accept.
- Exactly one transaction is outstanding. No request is accepted while in WAIT or RESP, and req_valid held high there is ignored.
- rsp_ready high while rsp_valid=0 has no effect.
- Address index is (req_addr-BASE_ADDR)>>2 using 32-bit unsigned arithmetic. Addresses below BASE wrap to large offsets.
- Reset mid-transaction:
  - WAIT/RESP are abandoned and no response is issued.
  - A store already committed at acceptance stays committed.
- req_valid may be deasserted by the initiator after acceptance without effect. Inputs are sampled only at the acceptance edge.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - A request is out of range if (req_addr-BASE_ADDR) >= DEPTH_WORDS*4.
  - An out-of-range store writes nothing; an out-of-range load returns rsp_rdata=0.
  - Both respond with rsp_err=1, with normal latency and handshake.
- Undefined:
  - No range check; the index is taken modulo DEPTH_WORDS (low log2(DEPTH_WORDS) bits), so the address aliases.
  - rsp_err is tied to 0.

Test Plan:
- Store then load: store addr 0x1004, wdata 0xDEADBEEF, wstrb 4'b1111, then load 0x1004. Required: rsp_rdata=0xDEADBEEF; rsp_valid rises 3 cycles after each accept cycle (LATENCY=2); rsp_err=0.
- Byte-lane store: word at 0x1008 preloaded 0x11223344; store wdata 0x0000AB00, wstrb 4'b0010. A load of 0x100A must return 0x1122AB44; this is the word the CPU lbu byte-selects.
- Response backpressure: hold rsp_ready=0 for 5 cycles during a load response. Required: rsp_valid=1, rdata stable, req_ready=0 with req_valid=1 asserted, and no second accept. On rsp_ready=1, return to IDLE and req_ready=1 the next cycle.
- Out of range: with DMEM_RANGE_CHECK_EN, store 0xFFFFFFFF to 0x1000+4096, then load the same address. Required: rsp_err=1 and rdata=0 on the load. Without the macro, the store aliases to word 0 and a load of 0x1000 returns 0xFFFFFFFF.
- Reset mid-operation: accept a load, then drive reset=0 for one edge while in WAIT. Required: rsp_valid never asserts, req_ready=1 after reset, array contents preserved.
- LATENCY=0 build: back-to-back load requests with rsp_ready=1. Required: each response one cycle after its accept, and accepts every 2 cycles.
